// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared types and helpers for the elevator direction scheduler.
//   elev_state_t : SCAN FSM states (IDLE, UP, DOWN, SERVE)
//   DIR_UP/DIR_DOWN : encodings of the committed direction bit
//   anyAbove/anyBelow/isHere : request-mask helpers over a pending bitmap.
//     Each takes the bitmap zero-extended to MAX_FLOORS bits, the car floor
//     and the number of floors actually present.
// ---------------------------------------------------------------------------
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    SERVE = 2'd3
  } elev_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Widest bitmap the helpers accept; narrower queues are zero-extended.
  localparam int MAX_FLOORS = 32;

  // True when any floor strictly above 'floor' has a pending request.
  function automatic logic anyAbove(input logic [MAX_FLOORS-1:0] queueBits,
                                    input int floor, input int nFloors);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if ((i < nFloors) && (i > floor)) hit = hit | queueBits[i];
    end
    return hit;
  endfunction

  // True when any floor strictly below 'floor' has a pending request.
  function automatic logic anyBelow(input logic [MAX_FLOORS-1:0] queueBits,
                                    input int floor, input int nFloors);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if ((i < nFloors) && (i < floor)) hit = hit | queueBits[i];
    end
    return hit;
  endfunction

  // Request bit at 'floor'; a floor outside the building reads as 0.
  function automatic logic isHere(input logic [MAX_FLOORS-1:0] queueBits,
                                  input int floor, input int nFloors);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if ((i < nFloors) && (i == floor)) hit = hit | queueBits[i];
    end
    return hit;
  endfunction

endpackage

// File: rtl/elevator_req_queue.sv
// ---------------------------------------------------------------------------
// elevator_req_queue
// Registered pending-request bitmap, bit i = floor i.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   req_valid_i/req_floor_i : set port; floors >= N_FLOORS are dropped
//   clr_en_i/clr_floor_i : clear port; a clear beats a set of the same bit
//   queue_o              : registered bitmap
//   empty_o              : registered flag, high when the bitmap is zero
// ---------------------------------------------------------------------------
module elevator_req_queue
#(
  parameter int N_FLOORS = 8,
  parameter int FLOOR_W  = $clog2(N_FLOORS)
)(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  input  logic [FLOOR_W-1:0]  req_floor_i,
  input  logic                clr_en_i,
  input  logic [FLOOR_W-1:0]  clr_floor_i,
  output logic [N_FLOORS-1:0] queue_o,
  output logic                empty_o
);

  logic [N_FLOORS-1:0] queue_q;
  logic [N_FLOORS-1:0] queue_d;
  logic [N_FLOORS-1:0] setMask;
  logic [N_FLOORS-1:0] clrMask;
  logic                empty_q;
  logic                setInRange;

  // Build one-hot set/clear masks. Applying the clear after the set makes a
  // request for the floor being cleared disappear in the same cycle.
  always_comb begin
    setMask    = '0;
    clrMask    = '0;
    setInRange = req_valid_i && (int'(req_floor_i) < N_FLOORS);
    for (int i = 0; i < N_FLOORS; i++) begin
      if (setInRange && (int'(req_floor_i) == i)) setMask[i] = 1'b1;
      if (clr_en_i && (int'(clr_floor_i) == i))   clrMask[i] = 1'b1;
    end
    queue_d = (queue_q | setMask) & ~clrMask;
  end

  // Bitmap and its empty flag are both registered so the flag never lags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      queue_q <= '0;
      empty_q <= 1'b1;
    end else begin
      queue_q <= queue_d;
      empty_q <= ~|queue_d;
    end
  end

  assign queue_o = queue_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/elevator_direction_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_direction_scheduler
// Latches floor requests and runs a SCAN direction FSM (IDLE/UP/DOWN/SERVE),
// clearing each request as its floor is served.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   req_valid_i/req_floor_i : one-cycle request strobe and floor
//   current_floor_i    : floor the car is at or passing
//   floor_valid_i      : car is level at current_floor_i this cycle
//   door_hold_i        : reloads the dwell counter (ELEV_DWELL_EN builds only)
//   queue_status_o     : pending bitmap; queue_empty_o when it is zero
//   next_up_ndown_o    : committed direction, 1 = up
//   move_en_o          : high while in UP or DOWN
//   serve_pulse_o      : one-cycle pulse on entry to SERVE
//   served_floor_o     : floor cleared by the most recent serve
// Build option: define ELEV_DWELL_EN to make SERVE last DWELL_CYCLES cycles
// (extended by door_hold_i); otherwise SERVE lasts one cycle.
// ---------------------------------------------------------------------------
module elevator_direction_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS     = 8,
  parameter int FLOOR_W      = $clog2(N_FLOORS),
  parameter int DWELL_CYCLES = 4
)(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  input  logic [FLOOR_W-1:0]  req_floor_i,
  input  logic [FLOOR_W-1:0]  current_floor_i,
  input  logic                floor_valid_i,
`ifdef ELEV_DWELL_EN
  input  logic                door_hold_i,
`endif
  output logic [N_FLOORS-1:0] queue_status_o,
  output logic                queue_empty_o,
  output logic                next_up_ndown_o,
  output logic                move_en_o,
  output logic                serve_pulse_o,
  output logic [FLOOR_W-1:0]  served_floor_o
);

  elev_state_t         state_q;
  elev_state_t         state_d;
  logic                dir_q;
  logic                dir_d;
  logic [N_FLOORS-1:0] queueBits;
  logic                queueEmpty;
  logic                aboveHit;
  logic                belowHit;
  logic                hereHit;
  logic                serveHere;
  logic                aheadHit;
  logic                behindHit;
  logic                evalRest;
  logic                dwellBusy;
  logic                enterServe;
  logic                clrEn;

  elevator_req_queue #(
    .N_FLOORS (N_FLOORS),
    .FLOOR_W  (FLOOR_W)
  ) reqQueue (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_floor_i (req_floor_i),
    .clr_en_i    (clrEn),
    .clr_floor_i (current_floor_i),
    .queue_o     (queueBits),
    .empty_o     (queueEmpty)
  );

  // Direction masks come from the registered queue only, never from this
  // cycle's request, so a new request influences the FSM one cycle later.
  always_comb begin
    aboveHit  = anyAbove(MAX_FLOORS'(queueBits), int'(current_floor_i), N_FLOORS);
    belowHit  = anyBelow(MAX_FLOORS'(queueBits), int'(current_floor_i), N_FLOORS);
    hereHit   = isHere(MAX_FLOORS'(queueBits), int'(current_floor_i), N_FLOORS);
    serveHere = hereHit && floor_valid_i;
    aheadHit  = (state_q == UP) ? aboveHit : belowHit;
    behindHit = (state_q == UP) ? belowHit : aboveHit;
  end

`ifdef ELEV_DWELL_EN
  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  logic [DWELL_W-1:0] dwellCnt_q;

  // SERVE is held while the door is held or dwell cycles remain.
  assign dwellBusy = door_hold_i || (dwellCnt_q != '0);

  // Dwell counter holds the number of SERVE cycles still to go after this
  // one; door_hold reloads it so the full dwell restarts on release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dwellCnt_q <= '0;
    end else if (state_d == SERVE) begin
      if ((state_q != SERVE) || door_hold_i) dwellCnt_q <= DWELL_W'(DWELL_CYCLES - 1);
      else                                   dwellCnt_q <= dwellCnt_q - 1'b1;
    end else begin
      dwellCnt_q <= '0;
    end
  end
`else
  logic unusedDwell;
  assign unusedDwell = ^DWELL_CYCLES;
  assign dwellBusy   = 1'b0;
`endif

  // SCAN next-state logic. UP/DOWN keep going while requests lie ahead and
  // reverse only when nothing remains ahead. IDLE and SERVE exit share one
  // evaluation that keeps the committed direction when both sides wait.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    evalRest = 1'b0;
    case (state_q)
      IDLE: evalRest = 1'b1;
      UP, DOWN: begin
        if (serveHere) begin
          state_d = SERVE;
        end else if (aheadHit) begin
          state_d = state_q;
        end else if (behindHit) begin
          state_d = (state_q == UP) ? DOWN : UP;
          dir_d   = (state_q == UP) ? DIR_DOWN : DIR_UP;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE: evalRest = !dwellBusy;
      default: state_d = IDLE;
    endcase
    if (evalRest) begin
      if (queueEmpty) begin
        state_d = IDLE;
      end else if (serveHere) begin
        state_d = SERVE;
      end else if (aboveHit && belowHit) begin
        state_d = (dir_q == DIR_UP) ? UP : DOWN;
      end else if (aboveHit) begin
        state_d = UP;
        dir_d   = DIR_UP;
      end else if (belowHit) begin
        state_d = DOWN;
        dir_d   = DIR_DOWN;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // The current floor is cleared on entry and kept clear for the whole of
  // SERVE, which also absorbs requests for it during the dwell.
  assign enterServe = (state_d == SERVE) && (state_q != SERVE);
  assign clrEn      = (state_d == SERVE) || (state_q == SERVE);

  // State, direction and all FSM outputs are registered together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      dir_q          <= DIR_UP;
      move_en_o      <= 1'b0;
      serve_pulse_o  <= 1'b0;
      served_floor_o <= '0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      move_en_o     <= (state_d == UP) || (state_d == DOWN);
      serve_pulse_o <= enterServe;
      if (enterServe) served_floor_o <= current_floor_i;
    end
  end

  assign queue_status_o  = queueBits;
  assign queue_empty_o   = queueEmpty;
  assign next_up_ndown_o = dir_q;

endmodule
